accum_capture: RTL
==================

Name: accum_capture

Overview:
- Downstream of the per-channel correlators; consumes each channel's dump strobe and its six signed 16-bit early/prompt/late I/Q accumulations.
- On every dump, snapshots that channel's six accumulations into holding registers and sets a per-channel new-data flag.
- Flags dumps that land before software has acknowledged the previous one as overruns.
- Raises a registered accumulation interrupt, and serves all captured data and status through a one-cycle-latency read port.

Parameters:
- NUM_CH, 12, number of tracking channels (1..16).
- CHW, $clog2(NUM_CH) (minimum 1), derived localparam, width of the channel index.

Ports:
- clk  in  1  system clock.
- rstn  in  1  synchronous active-low reset, sampled on rising clk.
- ch_dump  in  NUM_CH  per-channel dump strobe, one clk wide.
- ch_acc  in  NUM_CH*96  packed accumulations. Channel c occupies bits [c*96+95 : c*96]. Within a channel, 16-bit fields from LSB upward are: i_early, q_early, i_prompt, q_prompt, i_late, q_late.
- int_enable  in  1  interrupt enable.
- rd_en  in  1  data read strobe.
- rd_ch  in  CHW  channel select.
- rd_sel  in  3  field select, 0..5 in the field order above.
- rd_data  out  16  selected captured word.
- rd_valid  out  1  rd_data valid.
- status_rd  in  1  status read-and-clear strobe.
- status_new  out  NUM_CH  snapshot of new-data flags.
- status_ovr  out  NUM_CH  snapshot of overrun flags.
- new_data  out  NUM_CH  live new-data flags.
- accum_int  out  1  accumulation interrupt, level.

Behaviour:
- Reset (rstn=0 at a clk edge): all holding registers, new_data, overrun, rd_data, rd_valid, status_new, status_ovr and accum_int go to 0. Reset overrides every other input that cycle.
- Capture: when ch_dump[c]=1 at an edge, channel c's six fields are copied from ch_acc into its holding registers at that edge. The values sampled are those present in the same cycle as the dump strobe. Channels are independent; any number may dump in the same cycle.
- new_data[c]: set at the edge where ch_dump[c]=1; cleared at the edge where status_rd=1.
  - If ch_dump[c] and status_rd are both 1 in the same cycle, set wins and new_data[c] stays 1.
- overrun[c] (internal): set when ch_dump[c]=1 while new_data[c] is already 1; cleared by status_rd.
  - If ch_dump[c]=1, new_data[c]=1 and status_rd=1 in the same cycle, overrun[c] ends at 0: the pending flag is acknowledged by that read, so the new dump is not counted as an overrun.
  - On overrun, the new data still overwrites the holding registers.
- Status read: on an edge with status_rd=1, status_new and status_ovr load the flag values present before that edge's update. Both outputs hold until the next status_rd. The flags are then cleared, subject to the rules above.
- Data read: on an edge with rd_en=1, rd_data loads holding register [rd_ch][rd_sel] and rd_valid is 1 for one cycle. Latency is 1 clk.
  - rd_sel of 6 or 7, or rd_ch >= NUM_CH, gives rd_data=0 with rd_valid=1.
  - A read of channel c in the same cycle as ch_dump[c] returns the pre-capture value.
  - When rd_en=0, rd_data holds its last value and rd_valid=0.
- Reads do not affect flags. rd_en and status_rd may be asserted together; each acts independently.
- accum_int is registered: at each edge it loads int_enable & (OR of the next-state new_data).
  - It therefore rises the cycle after the first dump, and falls the cycle after the status_rd that clears all flags.
  - Deasserting int_enable drops accum_int one cycle later without clearing any flags.
- No handshake back-pressure; a dump is never lost, only overwritten.

Test Plan:
1. Reset, NUM_CH=12: all outputs 0 → after the first clk with rstn=1 and no stimulus, all outputs remain 0.
2. Channel 3 has ch_acc fields i_early=0x1234, q_late=0x8001 and ch_dump[3] pulses for one cycle, int_enable=1:
   - next cycle: new_data=0x008 and accum_int=1.
   - rd_en with rd_ch=3, rd_sel=0, then rd_sel=5: rd_data=0x1234, then 0x8001, each with rd_valid=1 one clk after its rd_en.
3. Overrun: ch_dump[5] pulses twice with no status_rd in between, the second with i_prompt=0x0042:
   - status_rd → status_new[5]=1, status_ovr[5]=1.
   - reading rd_ch=5, rd_sel=2 → 0x0042.
   - after the status_rd: new_data=0 and accum_int=0.
4. Collision: ch_dump[0] asserted in the same cycle as status_rd, with new_data[0] already 1:
   - status_new[0]=1, status_ovr[0]=0.
   - new_data[0] remains 1 afterwards and accum_int stays 1.
5. Same-cycle read and capture: channel 7 holds 0x1111; rd_en (rd_ch=7, rd_sel=0) coincides with ch_dump[7] carrying 0x2222 → rd_data=0x1111. The next read returns 0x2222.
6. Out-of-range read: rd_ch=13 or rd_sel=6 → rd_data=0, rd_valid=1. Also, int_enable=0 with new_data≠0 → accum_int=0.

Source files
------------

// File: rtl/accum_capture.sv
// accum_capture: snapshots per-channel correlator accumulations on each dump strobe,
// tracks new-data / overrun flags, raises a level accumulation interrupt and serves
// captured words and flag snapshots through a one-cycle-latency read port.
//
// Ports:
//   clk, rstn             clock, synchronous active-low reset
//   ch_dump[NUM_CH]       per-channel dump strobe
//   ch_acc[NUM_CH*96]     six signed 16-bit fields per channel (IE, QE, IP, QP, IL, QL)
//   int_enable            interrupt enable
//   rd_en, rd_ch, rd_sel  data read request -> rd_data / rd_valid one clk later
//   status_rd             read-and-clear of flags -> status_new / status_ovr
//   new_data              live new-data flags
//   accum_int             registered interrupt level
module accum_capture #(
    parameter int unsigned NUM_CH = 12,
    localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NUM_CH-1:0]    ch_dump,
    input  logic [NUM_CH*96-1:0] ch_acc,
    input  logic                 int_enable,
    input  logic                 rd_en,
    input  logic [CHW-1:0]       rd_ch,
    input  logic [2:0]           rd_sel,
    output logic [15:0]          rd_data,
    output logic                 rd_valid,
    input  logic                 status_rd,
    output logic [NUM_CH-1:0]    status_new,
    output logic [NUM_CH-1:0]    status_ovr,
    output logic [NUM_CH-1:0]    new_data,
    output logic                 accum_int
);

    localparam int unsigned NumFields = 6;

    logic [15:0]       hold_q [NUM_CH][NumFields];
    logic [15:0]       hold_d [NUM_CH][NumFields];
    logic [NUM_CH-1:0] new_q, new_d;
    logic [NUM_CH-1:0] ovr_q, ovr_d;
    logic [NUM_CH-1:0] status_new_q, status_new_d;
    logic [NUM_CH-1:0] status_ovr_q, status_ovr_d;
    logic [15:0]       rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              accum_int_q, accum_int_d;

    // Capture path: dumping channels overwrite their holding registers.
    always_comb begin
        hold_d = hold_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_dump[c]) begin
                for (int f = 0; f < NumFields; f++) begin
                    hold_d[c][f] = ch_acc[c*96 + f*16 +: 16];
                end
            end
        end
    end

    // Flags. A dump wins over the clear for new_data, while the same-cycle status
    // read acknowledges the pending flag so the colliding dump is not an overrun.
    always_comb begin
        new_d        = (new_q & ~{NUM_CH{status_rd}}) | ch_dump;
        ovr_d        = status_rd ? '0 : (ovr_q | (ch_dump & new_q));
        status_new_d = status_rd ? new_q : status_new_q;
        status_ovr_d = status_rd ? ovr_q : status_ovr_q;
        accum_int_d  = int_enable & (|new_d);
    end

    // Read port: out-of-range channel or field yields zero; reads see pre-capture data.
    always_comb begin
        rd_valid_d = rd_en;
        rd_data_d  = rd_data_q;
        if (rd_en) begin
            rd_data_d = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                for (int f = 0; f < NumFields; f++) begin
                    if (rd_ch == CHW'(c) && rd_sel == 3'(f)) begin
                        rd_data_d = hold_q[c][f];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            hold_q       <= '{default: '0};
            new_q        <= '0;
            ovr_q        <= '0;
            status_new_q <= '0;
            status_ovr_q <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            accum_int_q  <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            new_q        <= new_d;
            ovr_q        <= ovr_d;
            status_new_q <= status_new_d;
            status_ovr_q <= status_ovr_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            accum_int_q  <= accum_int_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign status_new = status_new_q;
    assign status_ovr = status_ovr_q;
    assign new_data   = new_q;
    assign accum_int  = accum_int_q;

endmodule
